div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Sequential signed 32-bit divider; the inverse-operation counterpart of the existing sequential multiplier.
- Shares the multiplier's HI/LO result convention and its ctrl/stop handshake.
- Result convention: LO = quotient, HI = remainder (MIPS DIV semantics).
- Instantiated in the datapath next to the multiplier; the control unit holds div_ctrl and waits for stop.

Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- A  input  WIDTH  dividend, two's complement; sampled only at the start edge
- B  input  WIDTH  divisor, two's complement; sampled only at the start edge
- div_ctrl  input  1  level start request; held high by control until stop is seen
- HI  output  WIDTH  remainder, registered
- LO  output  WIDTH  quotient, registered
- stop  output  1  one-cycle completion pulse
- div_zero  output  1  divide-by-zero flag, registered

Behaviour:
- Reset, sampled at any rising edge and in any state:
  - HI=0, LO=0, stop=0, div_zero=0.
  - State=IDLE; counter and internal registers cleared.
  - Reset has priority over all other inputs, so a reset mid-operation aborts the division with no partial result.
- States: IDLE, RUN, FINISH, DONE, WAIT_LOW.
- IDLE, start edge E0 (div_ctrl=1 sampled):
  - Latch sign_q = A[31]^B[31] and sign_r = A[31].
  - Latch |A| and |B| as unsigned values. Magnitude of 0x80000000 is 0x80000000.
  - Clear the partial remainder; counter=WIDTH.
  - If B==0, go to DONE with div_zero set at the same edge. Otherwise clear div_zero and go to RUN.
- RUN, edges E1..E32, one restoring step per edge:
  - Shift {rem, quo} left by one, shifting in the next dividend bit.
  - Trial-subtract |B| from the remainder. If no borrow, keep the difference and set the quotient LSB to 1.
  - The remainder register is WIDTH+1 bits so the trial subtract never overflows.
  - Decrement counter; at counter==1 go to FINISH.
- FINISH, edge E33:
  - LO = sign_q ? -quo : quo.
  - HI = sign_r ? -rem : rem.
  - stop=1; state=DONE.
  - Latency: stop and results are visible in the cycle after E33, i.e. 33 clocks after the start edge.
- Divide-by-zero path:
  - stop=1 in the cycle after E1 (E0 goes to DONE with div_zero=1; DONE raises stop).
  - HI and LO keep their previous values.
- DONE: stop=0 at the next edge; go to WAIT_LOW if div_ctrl=1, else IDLE. stop is never high for more than one cycle.
- WAIT_LOW: stay until div_ctrl sampled 0, then IDLE. A held div_ctrl never restarts a division.
- div_zero holds its value until the next accepted start.
- Changes to A or B after E0 are ignored. Deasserting div_ctrl during RUN does not abort.
- Rounding: quotient truncates toward zero; the remainder takes the dividend's sign.
- Overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 by natural wrap; no flag.
- |A| < |B| gives LO=0, HI=A.
- A==0 with B!=0 gives HI=LO=0.

Test Plan:
- A=42, B=5, div_ctrl held high -> stop pulses once, 33 clocks after the start edge; LO=8, HI=2, div_zero=0; no second stop while div_ctrl stays high.
- Signs: -7/2 -> LO=-3 (0xFFFFFFFD), HI=-1. 7/-2 -> LO=-3, HI=1. -7/-2 -> LO=3, HI=-1.
- Load HI/LO with 42/5 first, then A=9, B=0 -> div_zero=1 and stop in the cycle after E1; HI=2, LO=8 unchanged. A following 10/3 -> div_zero=0, LO=3, HI=1.
- Edge operands: 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. 3/10 -> LO=0, HI=3. 0xFFFFFFFF/1 -> LO=0xFFFFFFFF, HI=0.
- Assert reset at cycle 15 of a 100/7 run -> HI=LO=0, stop=0, state IDLE. A new 100/7 run completes normally with LO=14, HI=2.
- Change A and B on the cycle after E0 of 42/5 -> result is still LO=8, HI=2.

Source files
------------

// File: rtl/div_seq.sv
// Sequential signed restoring divider: one quotient bit per clock, MIPS DIV result
// convention (LO = quotient, HI = remainder) and the same ctrl/stop handshake as the multiplier.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             div_ctrl,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             stop,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RUN      = 3'd1;
   localparam logic [2:0] S_FINISH   = 3'd2;
   localparam logic [2:0] S_DONE     = 3'd3;
   localparam logic [2:0] S_WAIT_LOW = 3'd4;

   logic [2:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_sign_q;
   logic             r_sign_r;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_stop;
   logic             r_div_zero;

   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH+1:0] w_rem_sh;
   logic [WIDTH+1:0] w_diff;
   logic             w_borrow;

   // Two's-complement negate wraps 0x80000000 onto itself, which is its unsigned magnitude.
   assign w_abs_a = A[WIDTH-1] ? -A : A;
   assign w_abs_b = B[WIDTH-1] ? -B : B;

   // Partial remainder shifted left with the next dividend bit; the extra top bit is the borrow.
   assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
   assign w_diff   = w_rem_sh - {2'b00, r_div};
   assign w_borrow = w_diff[WIDTH+1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_quo      <= '0;
         r_rem      <= '0;
         r_div      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_stop     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_stop <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (div_ctrl) begin
                  r_sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                  r_sign_r <= A[WIDTH-1];
                  r_quo    <= w_abs_a;
                  r_div    <= w_abs_b;
                  r_rem    <= '0;
                  r_cnt    <= CW'(WIDTH);
                  if (B == '0) begin
                     r_div_zero <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_div_zero <= 1'b0;
                     r_state    <= S_RUN;
                  end
               end
            end

            S_RUN: begin
               r_rem <= w_borrow ? w_rem_sh[WIDTH:0] : w_diff[WIDTH:0];
               r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_FINISH;
               end
            end

            S_FINISH: begin
               r_lo    <= r_sign_q ? -r_quo : r_quo;
               r_hi    <= r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
               r_stop  <= 1'b1;
               r_state <= S_DONE;
            end

            // A normal result arrives here with stop already high; the divide-by-zero path
            // arrives straight from IDLE and raises its single stop pulse here instead.
            S_DONE: begin
               r_stop  <= r_div_zero;
               r_state <= div_ctrl ? S_WAIT_LOW : S_IDLE;
            end

            S_WAIT_LOW: begin
               if (!div_ctrl) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign HI       = r_hi;
   assign LO       = r_lo;
   assign stop     = r_stop;
   assign div_zero = r_div_zero;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes hand-computed results, a negedge monitor
// pops and compares them whenever stop is presented.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic        div_ctrl;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        stop;
   logic        div_zero;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic stop_prev = 1'b0;

   div_seq #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .A        (A),
      .B        (B),
      .div_ctrl (div_ctrl),
      .HI       (HI),
      .LO       (LO),
      .stop     (stop),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: every stop pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (stop) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_stop: got stop=1 with empty scoreboard, want no stop");
         end else begin
            mon_e = sb_q.pop_front();
            $display("txn %s: HI=%h LO=%h div_zero=%0d", mon_e.name, HI, LO, div_zero);
            chk({mon_e.name, ".HI"}, HI, mon_e.hi);
            chk({mon_e.name, ".LO"}, LO, mon_e.lo);
            chk({mon_e.name, ".div_zero"}, {31'b0, div_zero}, {31'b0, mon_e.dz});
         end
         if (stop_prev) begin
            total++;
            bad++;
            $display("FAIL stop_width: got stop high 2 cycles, want 1");
         end
      end
      stop_prev = stop;
   end

   task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int elat, input bit scramble);
      exp_t e;
      int   n;
      bit   seen;
      @(negedge clk);
      A = a;
      B = b;
      div_ctrl = 1'b1;
      e.hi = ehi;
      e.lo = elo;
      e.dz = edz;
      e.name = nm;
      sb_q.push_back(e);
      @(posedge clk);
      if (scramble) begin
         @(negedge clk);
         A = 32'h1234_5678;
         B = 32'h0000_0003;
      end
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (stop) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s.timeout: got no stop in 100 cycles, want stop", nm);
         sb_q.delete();
      end else begin
         chk({nm, ".latency"}, n, elat);
      end
      // Hold div_ctrl: the monitor flags any second stop as unexpected.
      repeat (5) @(posedge clk);
      @(negedge clk);
      div_ctrl = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      div_ctrl = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.HI", HI, 32'h0);
      chk("reset.LO", LO, 32'h0);
      chk("reset.stop", {31'b0, stop}, 32'h0);
      chk("reset.div_zero", {31'b0, div_zero}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);

      run_div("42/5",  32'd42, 32'd5, 32'd2, 32'd8, 1'b0, 33, 1'b0);
      run_div("-7/2",  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
      run_div("7/-2",  32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
      run_div("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b0, 33, 1'b0);
      run_div("42/5b", 32'd42, 32'd5, 32'd2, 32'd8, 1'b0, 33, 1'b0);
      run_div("9/0",   32'd9, 32'd0, 32'd2, 32'd8, 1'b1, 1, 1'b0);
      run_div("10/3",  32'd10, 32'd3, 32'd1, 32'd3, 1'b0, 33, 1'b0);
      run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 1'b0);
      run_div("3/10",  32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 33, 1'b0);
      run_div("0/5",   32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33, 1'b0);
      run_div("-1/1",  32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);

      // Abort a 100/7 run with reset partway through; no stop may follow.
      @(negedge clk);
      A = 32'd100;
      B = 32'd7;
      div_ctrl = 1'b1;
      @(posedge clk);
      repeat (15) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      div_ctrl = 1'b0;
      @(posedge clk);
      #1;
      chk("abort.HI", HI, 32'h0);
      chk("abort.LO", LO, 32'h0);
      chk("abort.stop", {31'b0, stop}, 32'h0);
      chk("abort.div_zero", {31'b0, div_zero}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(posedge clk);

      run_div("100/7",    32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b0);
      run_div("42/5scr",  32'd42, 32'd5, 32'd2, 32'd8, 1'b0, 33, 1'b1);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
